// File: rtl/bpsk_modulator.sv
// -----------------------------------------------------------------------------
// bpsk_modulator
//
// Turns a serial bit stream into a BPSK-modulated sine carrier. The block paces
// an external parallel-to-serial converter. It pulses `load` to fetch a word and
// `shift` to advance to the next bit. It reads the current bit on `serial_in`
// once per bit period. Each bit spans SAMPLES_PER_BIT output samples, and one
// sample is produced every SAMPLE_DIV clock cycles. The carrier is a 16-entry
// sine table. A '1' bit sends the table as is; a '0' bit sends it negated,
// which is a 180-degree phase flip.
//
// Parameters
//   BITS_PER_WORD    bits per serialiser word
//   SAMPLES_PER_BIT  output samples per bit (multiple of 16)
//   SAMPLE_DIV       clock cycles per output sample (>= 2)
//   OUT_WIDTH        signed output sample width
//
// Ports
//   clk           in   sole clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   begin transmission (looked at only while idle)
//   stop          in   end transmission once the current word is complete
//   serial_in     in   current bit from the serialiser
//   load          out  one-cycle pulse: serialiser captures its next word
//   shift         out  one-cycle pulse: serialiser advances one bit
//   sample        out  signed carrier sample
//   sample_valid  out  one-cycle pulse per new sample
//   word_done     out  one-cycle pulse with the last sample of a word
//   busy          out  high whenever the block is not idle
// -----------------------------------------------------------------------------
module bpsk_modulator #(
  parameter int BITS_PER_WORD   = 32,
  parameter int SAMPLES_PER_BIT = 32,
  parameter int SAMPLE_DIV      = 4,
  parameter int OUT_WIDTH       = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        serial_in,
  output logic                        load,
  output logic                        shift,
  output logic signed [OUT_WIDTH-1:0] sample,
  output logic                        sample_valid,
  output logic                        word_done,
  output logic                        busy
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SMP_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);

  // The quarter-wave sine values sin(k*pi/8), k = 1..3, are held as integers
  // scaled by 2^30. Each table entry is round(AMP * sin) in fixed point. The
  // scale is fine enough that the rounding is exact for any practical
  // OUT_WIDTH. The fourth point is sin(pi/2) = 1, which is AMP itself.
  localparam longint AMP        = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam longint ROUND_HALF = longint'(1) <<< 29;
  localparam longint SIN_1      = longint'(410903207);
  localparam longint SIN_2      = longint'(759250125);
  localparam longint SIN_3      = longint'(992008094);

  localparam logic signed [OUT_WIDTH-1:0] LEVEL_1 = OUT_WIDTH'((AMP * SIN_1 + ROUND_HALF) >>> 30);
  localparam logic signed [OUT_WIDTH-1:0] LEVEL_2 = OUT_WIDTH'((AMP * SIN_2 + ROUND_HALF) >>> 30);
  localparam logic signed [OUT_WIDTH-1:0] LEVEL_3 = OUT_WIDTH'((AMP * SIN_3 + ROUND_HALF) >>> 30);
  localparam logic signed [OUT_WIDTH-1:0] LEVEL_4 = OUT_WIDTH'(AMP);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t                        state;
  state_t                        next_state;

  logic [DIV_W-1:0]              div_cnt;
  logic [SMP_W-1:0]              sample_cnt;
  logic [BIT_W-1:0]              bit_cnt;
  logic                          cur_bit;
  logic                          stop_latch;
  logic                          finishing;

  logic                          tick;
  logic                          last_sample;
  logic                          last_bit;
  logic                          word_end;
  logic                          stop_pending;
  logic                          bit_now;
  logic signed [OUT_WIDTH-1:0]   carrier_value;
  logic signed [OUT_WIDTH-1:0]   tx_value;

  // One full carrier period is 16 points. The first half (k = 0..7) is the
  // positive lobe, mirrored around k = 4. The second half is the same lobe
  // negated. Negation cannot overflow because every magnitude is <= AMP.
  function automatic logic signed [OUT_WIDTH-1:0] carrier(input logic [3:0] k);
    logic signed [OUT_WIDTH-1:0] mag;
    case (k[2:0])
      3'd1, 3'd7: mag = LEVEL_1;
      3'd2, 3'd6: mag = LEVEL_2;
      3'd3, 3'd5: mag = LEVEL_3;
      3'd4:       mag = LEVEL_4;
      default:    mag = '0;
    endcase
    return k[3] ? -mag : mag;
  endfunction

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-cycle decode. `finishing` marks the single cycle
  // after the final word_done sample. That sample is still presented while
  // busy is high; the block then drops to IDLE with the sample cleared.
  always_comb begin
    next_state    = state;
    tick          = 1'b0;
    last_sample   = (sample_cnt == SMP_LAST);
    last_bit      = (bit_cnt == BIT_LAST);
    stop_pending  = stop_latch | stop;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = RUN;
      end
      RUN: begin
        if (finishing) begin
          next_state = IDLE;
        end else begin
          tick = (div_cnt == DIV_LAST);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    word_end      = tick & last_sample & last_bit;
    // The first sample of a bit uses the freshly presented serial bit directly.
    bit_now       = (sample_cnt == '0) ? serial_in : cur_bit;
    carrier_value = carrier(sample_cnt[3:0]);
    tx_value      = bit_now ? carrier_value : -carrier_value;
  end

  // Datapath: the divider, sample and bit counters, bit capture, the stop
  // latch and the registered output pulses. LOAD presets the divider to its
  // last count, so the first sample appears two cycles after the load pulse.
  // Every later sample follows SAMPLE_DIV cycles after the one before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      cur_bit      <= 1'b0;
      stop_latch   <= 1'b0;
      finishing    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      load         <= 1'b0;
      shift        <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      load         <= 1'b0;
      shift        <= 1'b0;
      word_done    <= 1'b0;
      case (state)
        IDLE: begin
          stop_latch <= 1'b0;
          finishing  <= 1'b0;
          sample     <= '0;
          div_cnt    <= '0;
          sample_cnt <= '0;
          bit_cnt    <= '0;
          if (start) begin
            load <= 1'b1;
          end
        end
        LOAD: begin
          stop_latch <= stop_latch | stop;
          div_cnt    <= DIV_LAST;
          sample_cnt <= '0;
          bit_cnt    <= '0;
        end
        RUN: begin
          if (finishing) begin
            finishing  <= 1'b0;
            stop_latch <= 1'b0;
            sample     <= '0;
            div_cnt    <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end else begin
            stop_latch <= stop_pending;
            if (tick) begin
              div_cnt      <= '0;
              sample_valid <= 1'b1;
              sample       <= tx_value;
              cur_bit      <= bit_now;
              if (last_sample) begin
                sample_cnt <= '0;
                bit_cnt    <= last_bit ? '0 : bit_cnt + BIT_W'(1);
                if (!last_bit) begin
                  shift <= 1'b1;
                end
              end else begin
                sample_cnt <= sample_cnt + SMP_W'(1);
              end
              // At the end of a word, either fetch the next word with no gap
              // or finish up and go idle.
              if (word_end) begin
                word_done <= 1'b1;
                if (stop_pending) begin
                  finishing <= 1'b1;
                end else begin
                  load <= 1'b1;
                end
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end
        default: begin
          finishing <= 1'b0;
        end
      endcase
    end
  end

endmodule
